// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, instruction
// field positions and the default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 8;
    localparam int RS_MSB     = 7;
    localparam int RS_LSB     = 4;
    localparam int OFFSET_MSB = 3;
    localparam int OFFSET_LSB = 0;

    function automatic logic [15:0] pc_next(input logic [15:0] pc);
        return pc + 16'h0001;
    endfunction

endpackage

// File: rtl/fetch_unit_instr_fields.sv
// Combinational splitter of a 16-bit instruction into opcode/rd/rs/offset;
// shared with decode.
module instr_fields
    import fetch_pkg::*;
(
    input  logic [15:0] instr,
    output logic [3:0]  opcode,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  offset
);

    assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign offset = instr[OFFSET_MSB:OFFSET_LSB];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch from instruction memory, valid/ready
// hand-off to decode. Define FETCH_BRANCH_EN to add PC-relative branch redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [3:0]  if_opcode,
    output logic [3:0]  if_rd,
    output logic [3:0]  if_rs,
    output logic [3:0]  if_offset
`ifdef FETCH_BRANCH_EN
    ,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset
`endif
);

    fetch_state_e state_r;
    logic [15:0]  pc_r;
    logic [15:0]  instr_r;
    logic [15:0]  if_pc_r;
    logic         hold_valid_s;

`ifdef FETCH_BRANCH_EN
    logic [15:0]  last_pc_r;
    logic [15:0]  kill_target_r;
    logic         kill_r;
    logic [15:0]  target_s;

    assign target_s = pc_next(last_pc_r) + branch_offset;
`endif

    // Fetch FSM with PC, held instruction and redirect bookkeeping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            instr_r       <= 16'h0000;
            if_pc_r       <= 16'h0000;
`ifdef FETCH_BRANCH_EN
            last_pc_r     <= RESET_PC - 16'h0001;
            kill_r        <= 1'b0;
            kill_target_r <= 16'h0000;
`endif
        end else begin
            case (state_r)
                IDLE: begin
`ifdef FETCH_BRANCH_EN
                    if (branch_taken) begin
                        pc_r <= target_s;
                    end
`endif
                    state_r <= REQ;
                end
                REQ: begin
                    if (imem_ack) begin
`ifdef FETCH_BRANCH_EN
                        // A killed or same-cycle-redirected response is dropped
                        if (kill_r) begin
                            pc_r   <= kill_target_r;
                            kill_r <= 1'b0;
                        end else if (branch_taken) begin
                            pc_r <= target_s;
                        end else
`endif
                        begin
                            instr_r <= imem_rdata;
                            if_pc_r <= pc_r;
                            pc_r    <= pc_next(pc_r);
                            state_r <= HOLD;
                        end
                    end
`ifdef FETCH_BRANCH_EN
                    else if (branch_taken) begin
                        // Request already on the bus must complete at the old address
                        kill_r        <= 1'b1;
                        kill_target_r <= target_s;
                    end
`endif
                end
                HOLD: begin
`ifdef FETCH_BRANCH_EN
                    if (branch_taken) begin
                        pc_r    <= target_s;
                        state_r <= REQ;
                    end else
`endif
                    if (if_ready) begin
                        state_r <= REQ;
`ifdef FETCH_BRANCH_EN
                        last_pc_r <= if_pc_r;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign hold_valid_s = (state_r == HOLD);
    assign imem_req     = (state_r == REQ);
    assign imem_addr    = pc_r;
    assign if_instr     = instr_r;
    assign if_pc        = if_pc_r;

`ifdef FETCH_BRANCH_EN
    assign if_valid = hold_valid_s & ~branch_taken;
`else
    assign if_valid = hold_valid_s;
`endif

    instr_fields u_fields (
        .instr  (instr_r),
        .opcode (if_opcode),
        .rd     (if_rd),
        .rs     (if_rs),
        .offset (if_offset)
    );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit processor datapath. Maintains the program counter and fetches one 16-bit instruction at a time from instruction memory over a req/ack handshake. Holds the instruction and presents its fields to decode over a valid/ready handshake; the 4-bit `if_offset` field feeds the offset sign extender directly. Optionally accepts PC-relative branch redirects using the sign-extended 16-bit offset.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset (word address).

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; held until `imem_ack`.
- `imem_addr`  out  16  word address of the fetch (current PC); stable while `imem_req` is high.
- `imem_ack`  in  1  memory response; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  16  fetched instruction.
- `if_valid`  out  1  held instruction valid.
- `if_ready`  in  1  decode accepts the instruction when `if_valid & if_ready`.
- `if_instr`  out  16  held instruction.
- `if_pc`  out  16  address of the held instruction.
- `if_opcode`  out  4  `if_instr[15:12]`.
- `if_rd`  out  4  `if_instr[11:8]`.
- `if_rs`  out  4  `if_instr[7:4]`.
- `if_offset`  out  4  `if_instr[3:0]`; to the sign extender.
- `branch_taken`  in  1  redirect pulse (only with `FETCH_BRANCH_EN`).
- `branch_offset`  in  16  sign-extended offset (only with `FETCH_BRANCH_EN`).

## Operation
- FSM states: IDLE, REQ, HOLD.
- IDLE: entered on reset; one cycle; then REQ.
- REQ: `imem_req`=1, `imem_addr`=PC. On `imem_ack`: register `imem_rdata` into `if_instr`, PC into `if_pc`, PC <= PC+1 (mod 2^16, FFFF wraps to 0000), go HOLD. Without ack: stay in REQ, address and request unchanged.
- HOLD: `if_valid`=1, all `if_*` outputs stable. On `if_ready`: go REQ next cycle; `if_valid` drops. No ack arriving in HOLD is legal; memory must not ack without a request.
- `last_pc` register: updated to `if_pc` on every accepted handshake; reset to `RESET_PC - 1`.
- Branch (macro on): target = `last_pc` + 1 + `branch_offset`, mod 2^16.
  - In HOLD: held instruction discarded; PC <= target; go REQ.
  - In REQ with no ack in the same cycle: request stays high at the old address until ack; set `kill`; returned data discarded; then PC <= target and re-request (REQ with kill cleared).
  - In REQ with ack in the same cycle: ack data discarded, PC <= target, stay REQ.
  - In IDLE: PC <= target.
  - `if_valid` is combinationally gated: `if_valid` = hold_valid & ~`branch_taken`; a handshake coinciding with `branch_taken` does not occur and does not update `last_pc`.
- Reset mid-operation: all state returns to reset values immediately; an outstanding memory request is abandoned (memory is reset by the same `reset_n`).

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0, all field outputs 0, state IDLE, `kill`=0.
- First `imem_req` in cycle 1 after reset release.
- Ack-to-`if_valid`: 1 cycle (registered).
- Accept-to-next-request: 1 cycle; peak throughput one instruction per 2 cycles at single-cycle ack.
- Branch-to-target request: next cycle from HOLD/IDLE; ack + 1 cycle from REQ with a request outstanding.

## Configuration
- `FETCH_BRANCH_EN` defined: `branch_taken`/`branch_offset` ports, `last_pc`, `kill`, and redirect logic present.
- Not defined: ports absent, purely sequential fetch; `if_valid` = hold_valid.

## Structure
- Shared package `fetch_pkg`: state enum (IDLE, REQ, HOLD), instruction field bit positions (opcode 15:12, rd 11:8, rs 7:4, offset 3:0), default `RESET_PC`.
- One sub-module: `instr_fields`, combinational splitter of `if_instr` into opcode/rd/rs/offset, reused by decode.

## Test plan
- Reset release, `RESET_PC`=0 -> `imem_req`=1, `imem_addr`=0000 one cycle later; ack with 16'h1235 -> next cycle `if_valid`=1, `if_opcode`=1, `if_rd`=2, `if_rs`=3, `if_offset`=5, `if_pc`=0000.
- `if_ready` low 5 cycles -> outputs stable, no `imem_req`; `if_ready` high -> next `imem_addr`=0001.
- Ack delayed 3 cycles -> `imem_req` and `imem_addr` stable throughout; single capture.
- PC at FFFF fetched and accepted -> next `imem_addr`=0000.
- Macro on: `last_pc`=0010, HOLD, `branch_taken` with offset 16'hFFFC -> held instr dropped, `if_valid`=0 same cycle, next `imem_addr`=000D; repeat in REQ with ack 2 cycles later -> old data discarded, then request 000D.
- Assert `reset_n` low during outstanding REQ -> all outputs to reset values immediately; restart at `RESET_PC`.
